// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding and
// the default register-specifier width.
package hazard_ctrl_pkg;

  localparam int unsigned HZ_REG_AW = 5;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MD_BUSY = 1'b1;

  typedef enum logic [0:0] {
    IDLE    = ST_IDLE,
    MD_BUSY = ST_MD_BUSY
  } hz_state_e;

endpackage

// File: rtl/hazard_stall_cnt.sv
// Saturating counter of stalled cycles with synchronous clear.
module hazard_stall_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  // Holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch squash and (with
// HAZARD_MDU_EN defined) multi-cycle multiply/divide stalls.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = HZ_REG_AW,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_br_taken,
  input  logic              ex_md_start,
  input  logic              md_done,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_ex_stall,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic load_use;
  logic md_stall;

  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs && (id_rs == ex_rd)) ||
                     (id_use_rt && (id_rt == ex_rd)));

`ifdef HAZARD_MDU_EN
  hz_state_e state_q;
  hz_state_e state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A result arriving in the start cycle means no wait and no state change.
  always_comb begin
    state_d  = state_q;
    md_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_md_start && !md_done) begin
          state_d  = MD_BUSY;
          md_stall = 1'b1;
        end
      end
      MD_BUSY: begin
        if (md_done) begin
          state_d = IDLE;
        end else begin
          md_stall = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end
`else
  logic unused_md;

  assign unused_md = ex_md_start ^ md_done;
  assign md_stall  = 1'b0;
`endif

  // Priority: multiply/divide wait, taken branch, load-use bubble.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (!rst) begin
      if (md_stall) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (ex_br_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  hazard_stall_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (pc_stall),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; multiply/divide cases run
// only when HAZARD_MDU_EN is defined.
module tb_hazard_ctrl;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CNT_W4 = 4;

  // Packed as {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush}
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_LU   = 6'b110010;
  localparam logic [5:0] C_BR   = 6'b001010;
  localparam logic [5:0] C_MD   = 6'b110101;

  logic              clk;
  logic              rst;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_read;
  logic              ex_br_taken;
  logic              ex_md_start;
  logic              md_done;

  logic              pc_stall, if_id_stall, if_id_flush;
  logic              id_ex_stall, id_ex_flush, ex_mem_flush;
  logic [CNT_W-1:0]  stall_cnt;
  logic              pc_stall4, if_id_stall4, if_id_flush4;
  logic              id_ex_stall4, id_ex_flush4, ex_mem_flush4;
  logic [CNT_W4-1:0] stall_cnt4;
  logic [5:0]        ctrl;
  logic [5:0]        ctrl4;

  int unsigned n_checks;
  int unsigned n_errors;

  hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
    .ex_md_start(ex_md_start), .md_done(md_done),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W4)) dut4 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
    .ex_md_start(ex_md_start), .md_done(md_done),
    .pc_stall(pc_stall4), .if_id_stall(if_id_stall4), .if_id_flush(if_id_flush4),
    .id_ex_stall(id_ex_stall4), .id_ex_flush(id_ex_flush4),
    .ex_mem_flush(ex_mem_flush4), .stall_cnt(stall_cnt4)
  );

  assign ctrl  = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush};
  assign ctrl4 = {pc_stall4, if_id_stall4, if_id_flush4, id_ex_stall4, id_ex_flush4, ex_mem_flush4};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_rd = '0; ex_mem_read = 1'b0; ex_br_taken = 1'b0;
    ex_md_start = 1'b0; md_done = 1'b0;
  endtask

  task automatic set_lu_rs(input logic [REG_AW-1:0] r);
    ex_mem_read = 1'b1; ex_rd = r; id_rs = r; id_use_rs = 1'b1;
  endtask

  // Combinational outputs of both instances against one expected code.
  task automatic check_ctrl(input string tag, input logic [5:0] exp);
    #1;
    check(tag, 32'(ctrl), 32'(exp));
    check({tag, "_w4"}, 32'(ctrl4), 32'(exp));
  endtask

  task automatic check_cnt(input string tag, input int unsigned exp16, input int unsigned exp4);
    check({tag, "_cnt"}, 32'(stall_cnt), exp16);
    check({tag, "_cnt4"}, 32'(stall_cnt4), exp4);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clr_in();
    rst = 1'b1;
    tick();

    // Reset masks an active load-use hazard and holds the counters at zero.
    set_lu_rs(5'd5);
    check_ctrl("rst_mask", C_NONE);
    tick();
    check_cnt("rst", 0, 0);
    rst = 1'b0;
    clr_in();
    check_ctrl("idle", C_NONE);

    // Load r5 in EX, ID reads rs=r5: one bubble.
    set_lu_rs(5'd5);
    check_ctrl("lu_rs", C_LU);
    tick();
    check_cnt("lu_rs", 1, 1);
    clr_in();
    check_ctrl("lu_rs_after", C_NONE);
    tick();
    check_cnt("lu_rs_after", 1, 1);

    // rt match counts only when rt is actually read.
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_use_rt = 1'b0;
    check_ctrl("rt_unused", C_NONE);
    id_use_rt = 1'b1;
    check_ctrl("lu_rt", C_LU);
    tick();
    check_cnt("lu_rt", 2, 2);

    // Register 0 never creates a dependency; non-load never stalls.
    clr_in();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    check_ctrl("lu_r0", C_NONE);
    clr_in();
    ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    check_ctrl("no_load", C_NONE);
    ex_mem_read = 1'b1; id_rs = 5'd6;
    check_ctrl("lu_diff_reg", C_NONE);

    // Taken branch beats load-use and does not count.
    clr_in();
    set_lu_rs(5'd9);
    ex_br_taken = 1'b1;
    check_ctrl("br_lu", C_BR);
    tick();
    check_cnt("br_lu", 2, 2);
    clr_in();
    ex_br_taken = 1'b1;
    check_ctrl("br_only", C_BR);
    tick();
    clr_in();

`ifdef HAZARD_MDU_EN
    // Four-cycle multiply/divide wait, released on the md_done cycle.
    ex_md_start = 1'b1;
    check_ctrl("md_c0", C_MD);
    tick();
    check_ctrl("md_c1", C_MD);
    tick();
    ex_br_taken = 1'b1;
    set_lu_rs(5'd3);
    check_ctrl("md_c2_prio", C_MD);
    tick();
    clr_in();
    ex_md_start = 1'b1;
    check_ctrl("md_c3", C_MD);
    tick();
    md_done = 1'b1;
    check_ctrl("md_done", C_NONE);
    tick();
    check_cnt("md", 6, 6);
    clr_in();
    check_ctrl("md_idle", C_NONE);

    // Single-cycle result: no stall, FSM stays idle.
    ex_md_start = 1'b1; md_done = 1'b1;
    check_ctrl("md_1cyc", C_NONE);
    tick();
    clr_in();
    check_ctrl("md_1cyc_after", C_NONE);
    check_cnt("md_1cyc", 6, 6);

    // Enter MD_BUSY before the reset below.
    ex_md_start = 1'b1;
    tick();
    check_ctrl("md_busy_pre_rst", C_MD);
    tick();
`else
    // Multiply/divide inputs have no effect without the MDU option.
    ex_md_start = 1'b1;
    check_ctrl("md_ignored", C_NONE);
    tick();
    md_done = 1'b1;
    check_ctrl("md_done_ignored", C_NONE);
    tick();
    check_cnt("md_ignored", 2, 2);
    ex_md_start = 1'b0; md_done = 1'b0;
`endif

    // Mid-run reset: outputs drop immediately, counters clear, FSM idle.
    rst = 1'b1;
    set_lu_rs(5'd4);
    check_ctrl("rst_mid", C_NONE);
    tick();
    check_cnt("rst_mid", 0, 0);
    rst = 1'b0;
    clr_in();
    check_ctrl("rst_mid_after", C_NONE);

    // Twenty consecutive load-use stalls: 4-bit counter saturates at 0xF.
    set_lu_rs(5'd12);
    for (int i = 0; i < 15; i++) tick();
    check_cnt("sat15", 15, 15);
    check_ctrl("sat_lu", C_LU);
    for (int i = 0; i < 5; i++) tick();
    check_cnt("sat20", 20, 15);
    clr_in();
    tick();
    check_cnt("sat_hold", 20, 15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: REG_AW, default 5, register-specifier width.
REQ-002 Parameter: CNT_W, default 16, stall-cycle counter width.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 id_rs, id_rt  in  REG_AW each  source specifiers of instruction in ID.
REQ-006 id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt.
REQ-007 ex_rd  in  REG_AW  destination specifier of instruction in EX.
REQ-008 ex_mem_read  in  1  EX instruction is a load.
REQ-009 ex_br_taken  in  1  EX resolved a taken branch/jump.
REQ-010 ex_md_start  in  1  EX holds a multi-cycle multiply/divide op.
REQ-011 md_done  in  1  multiply/divide unit result valid this cycle.
REQ-012 pc_stall  out  1  hold PC.
REQ-013 if_id_stall  out  1  hold IF/ID register (drives its stall input).
REQ-014 if_id_flush  out  1  load NOP into IF/ID.
REQ-015 id_ex_stall  out  1  hold ID/EX register.
REQ-016 id_ex_flush  out  1  load bubble into ID/EX.
REQ-017 ex_mem_flush  out  1  load bubble into EX/MEM.
REQ-018 stall_cnt  out  CNT_W  count of cycles with pc_stall=1.

Function
REQ-019 load_use = ex_mem_read & (ex_rd!=0) & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
REQ-020 FSM states IDLE, MD_BUSY; IDLE->MD_BUSY when ex_md_start=1; MD_BUSY->IDLE when md_done=1; otherwise hold.
REQ-021 md_stall = (IDLE & ex_md_start & !md_done) | (MD_BUSY & !md_done); md_done in IDLE with ex_md_start (single-cycle result) gives no stall and no state change.
REQ-022 Priority, highest first: md_stall, ex_br_taken, load_use, none.
REQ-023 md_stall: pc_stall=if_id_stall=id_ex_stall=ex_mem_flush=1, all others 0.
REQ-024 ex_br_taken (no md_stall): if_id_flush=id_ex_flush=1, all others 0; load_use ignored (ID instruction is squashed).
REQ-025 load_use (no higher): pc_stall=if_id_stall=id_ex_flush=1, all others 0; exactly one bubble per load-use pair.
REQ-026 None active: all control outputs 0.
REQ-027 All control outputs combinational from current inputs and state, zero-cycle latency.
REQ-028 stall_cnt increments by 1 on each posedge where pc_stall=1; saturates at all-ones, no wrap.
REQ-029 md_done while MD_BUSY releases all stalls in that same cycle.

Reset
REQ-030 rst=1 at posedge: state<=IDLE, stall_cnt<=0.
REQ-031 While rst=1, all control outputs are 0 regardless of inputs; stall_cnt does not increment.
REQ-032 rst asserted in MD_BUSY aborts the wait; next cycle state is IDLE.

Configuration
REQ-033 Macro HAZARD_MDU_EN: defined -> FSM and REQ-020..023/029 present; undefined -> no FSM, ex_md_start/md_done ignored, id_ex_stall=ex_mem_flush=0 constant, only branch/load-use logic.

Structure
REQ-034 Shared package holds FSM state enum (IDLE, MD_BUSY) and REG_AW default; CNT_W stays local.
REQ-035 One sub-module: hazard_stall_cnt (saturating CNT_W counter, enable=pc_stall, sync clear).

Verification
REQ-036 Load r5 in EX, ID reads rs=5 with id_use_rs=1 -> one cycle pc_stall=if_id_stall=id_ex_flush=1, stall_cnt 0->1.
REQ-037 Load with ex_rd=0, ID rs=0 -> no stall, all outputs 0.
REQ-038 ex_br_taken=1 with simultaneous load_use -> if_id_flush=id_ex_flush=1, pc_stall=0, stall_cnt unchanged.
REQ-039 ex_md_start=1, md_done after 4 cycles -> 4 cycles of pc_stall/if_id_stall/id_ex_stall/ex_mem_flush=1, release on md_done cycle, stall_cnt +4.
REQ-040 rst=1 during MD_BUSY cycle 2 -> outputs 0 immediately, state IDLE, stall_cnt=0 next cycle.
REQ-041 CNT_W=4, 20 consecutive load-use stalls -> stall_cnt holds 0xF.
